dmem_arbiter: RTL and testbench
===============================

DMEM_ARBITER -- requirements
Module: dmem_arbiter

Interface
REQ-001 The block SHALL have parameter ADDR_W, default 8, giving the memory address width.
REQ-002 The block SHALL have parameter DATA_W, default 8, giving the memory data width.
REQ-003 The block SHALL have these ports; the clock is clk and the reset is rst_n, active-low and synchronous:
  clk  input  1  sole clock, all logic on rising edge
  rst_n  input  1  synchronous active-low reset
  req0 / req1  input  1  access request, port 0 = CPU, port 1 = DMA
  we0 / we1  input  1  1 = write, 0 = read
  add0 / add1  input  ADDR_W  request address
  wdata0 / wdata1  input  DATA_W  write data
  gnt0 / gnt1  output  1  one-cycle accept pulse
  rvalid0 / rvalid1  output  1  one-cycle read-data-valid pulse
  rdata0 / rdata1  output  DATA_W  read data, held until the next read completes on that port
  busy  output  1  high in any non-IDLE state
  mem_add  output  ADDR_W  memory address
  mem_data  inout  DATA_W  memory data bus
  mem_en  output  1  memory enable
  mem_wr_rd_n  output  1  1 = write, 0 = read

Function
REQ-004 The FSM SHALL have exactly four states, IDLE, ACC, RD and RET, with reset state IDLE.
REQ-005 In IDLE with at least one reqN high, the block SHALL assert the winner's gntN combinationally in that same cycle, latch its we/add/wdata/port index at the edge, and go to ACC.
REQ-006 The block SHALL assert gnt0/gnt1 only in IDLE, and never both in the same cycle.
REQ-007 In ACC the block SHALL drive mem_en=1, mem_add=latched address and mem_wr_rd_n=latched we; it SHALL go to IDLE for a write and to RD for a read.
REQ-008 The block SHALL drive mem_data with latched wdata only in ACC for a write; in every other cycle it SHALL drive mem_data high-Z.
REQ-009 In RD the block SHALL hold mem_en=0, sample mem_data at the closing edge into the owning port's rdata, and go to RET.
REQ-010 In RET the block SHALL pulse the owner's rvalidN for one cycle and go to IDLE.
REQ-011 Latency SHALL be fixed: a write occupies 2 cycles (grant, ACC); a read occupies 4 cycles (grant, ACC, RD, RET), with rvalid 3 cycles after gnt.
REQ-012 When mem_en=0, mem_add and mem_wr_rd_n SHALL be 0.
REQ-013 A request not granted SHALL stay pending with no loss while its reqN is held; requesters SHALL hold req/we/add/wdata stable until gnt.
REQ-014 Changes on reqN, weN, addN or wdataN after gnt SHALL NOT affect the access in flight.
REQ-015 With only one req high in IDLE, that port SHALL win regardless of history.
REQ-016 With both req high in IDLE, the winner SHALL be selected per REQ-021/REQ-022.
REQ-017 The block SHALL grant back-to-back: a request held through RET or a write's ACC SHALL be granted in the next IDLE cycle.

Reset
REQ-018 While rst_n=0 at a rising edge, the state SHALL become IDLE; gnt*, rvalid*, busy, mem_en, mem_add and mem_wr_rd_n SHALL be 0; rdata0/rdata1 SHALL be 0; mem_data SHALL be high-Z; and the round-robin pointer SHALL be set to favour port 0.
REQ-019 A reset during ACC, RD or RET SHALL abort the access, so no rvalid is issued for it; a write reset in ACC SHALL still complete if its edge coincides with the memory write.
REQ-020 During reset, gnt SHALL be suppressed even if req is high.

Configuration
REQ-021 With DMEM_ARB_FIXED_PRIO_EN defined, port 0 SHALL always win simultaneous requests, and the round-robin pointer SHALL be absent.
REQ-022 Without DMEM_ARB_FIXED_PRIO_EN, simultaneous requests SHALL go to the port not granted most recently, with the pointer updated on every grant.

Verification
REQ-023 Write then read on port 0: req0, we0=1, add0=0x12, wdata0=0xA5; then a read of 0x12 -> gnt0 in cycle 0, mem_en/mem_wr_rd_n=1 with mem_data=0xA5 in cycle 1; the read's rvalid0 comes 3 cycles after its gnt0 with rdata0=0xA5.
REQ-024 Round robin: req0 and req1 held high with reads, macro undefined -> grants alternate 0,1,0,1, with gnt spacing of 4 cycles.
REQ-025 Fixed priority: same stimulus as REQ-024 with DMEM_ARB_FIXED_PRIO_EN defined -> only gnt0 is asserted while req0 is held; gnt1 follows the first IDLE after req0 drops.
REQ-026 Reset mid-read: rst_n=0 in RD -> no rvalid, all outputs 0, mem_data high-Z, next req1 granted in the first cycle after rst_n=1.
REQ-027 Input change after grant: add1 changed from 0x05 to 0x06 in the cycle after gnt1 -> mem_add=0x05 in ACC.
REQ-028 Bus release: every non-write-ACC cycle -> mem_data high-Z, checked on every cycle of REQ-024.

Source files
------------

// File: rtl/dmem_arbiter.sv
// Two-port (CPU/DMA) arbiter in front of a single-ported data memory with a shared tristate bus.
// Define DMEM_ARB_FIXED_PRIO_EN for fixed port-0 priority; otherwise ties are resolved round-robin.
module dmem_arbiter #(
    parameter int unsigned ADDR_W = 8,
    parameter int unsigned DATA_W = 8
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              req0,
    input  logic              req1,
    input  logic              we0,
    input  logic              we1,
    input  logic [ADDR_W-1:0] add0,
    input  logic [ADDR_W-1:0] add1,
    input  logic [DATA_W-1:0] wdata0,
    input  logic [DATA_W-1:0] wdata1,
    output logic              gnt0,
    output logic              gnt1,
    output logic              rvalid0,
    output logic              rvalid1,
    output logic [DATA_W-1:0] rdata0,
    output logic [DATA_W-1:0] rdata1,
    output logic              busy,
    output logic [ADDR_W-1:0] mem_add,
    inout  wire  [DATA_W-1:0] mem_data,
    output logic              mem_en,
    output logic              mem_wr_rd_n
);

    typedef enum logic [1:0] {StIdle, StAcc, StRd, StRet} state_e;

    state_e              state_q, state_d;
    logic                we_q, we_d;
    logic [ADDR_W-1:0]   add_q, add_d;
    logic [DATA_W-1:0]   wdata_q, wdata_d;
    logic                own_q, own_d;
    logic [DATA_W-1:0]   rdata0_q, rdata0_d;
    logic [DATA_W-1:0]   rdata1_q, rdata1_d;
    logic                pick1;
    logic                bus_drv;
`ifndef DMEM_ARB_FIXED_PRIO_EN
    logic                last_q, last_d;
`endif

    // pick1 selects port 1 as the winner whenever it requests and port 0 does not take precedence.
`ifdef DMEM_ARB_FIXED_PRIO_EN
    assign pick1 = req1 && !req0;
`else
    assign pick1 = req1 && (!req0 || !last_q);
`endif

    always_comb begin
        state_d     = state_q;
        we_d        = we_q;
        add_d       = add_q;
        wdata_d     = wdata_q;
        own_d       = own_q;
        rdata0_d    = rdata0_q;
        rdata1_d    = rdata1_q;
`ifndef DMEM_ARB_FIXED_PRIO_EN
        last_d      = last_q;
`endif
        gnt0        = 1'b0;
        gnt1        = 1'b0;
        rvalid0     = 1'b0;
        rvalid1     = 1'b0;
        mem_en      = 1'b0;
        mem_wr_rd_n = 1'b0;
        mem_add     = '0;
        bus_drv     = 1'b0;
        busy        = (state_q != StIdle);

        unique case (state_q)
            StIdle: begin
                if (rst_n && (req0 || req1)) begin
                    gnt0    = !pick1;
                    gnt1    = pick1;
                    we_d    = pick1 ? we1 : we0;
                    add_d   = pick1 ? add1 : add0;
                    wdata_d = pick1 ? wdata1 : wdata0;
                    own_d   = pick1;
`ifndef DMEM_ARB_FIXED_PRIO_EN
                    last_d  = pick1;
`endif
                    state_d = StAcc;
                end
            end
            StAcc: begin
                mem_en      = 1'b1;
                mem_add     = add_q;
                mem_wr_rd_n = we_q;
                bus_drv     = we_q;
                state_d     = we_q ? StIdle : StRd;
            end
            StRd: begin
                if (own_q) rdata1_d = mem_data;
                else       rdata0_d = mem_data;
                state_d = StRet;
            end
            StRet: begin
                // A reset arriving in this cycle aborts the access, so the pulse is withheld.
                rvalid0 = rst_n && !own_q;
                rvalid1 = rst_n && own_q;
                state_d = StIdle;
            end
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q  <= StIdle;
            we_q     <= 1'b0;
            add_q    <= '0;
            wdata_q  <= '0;
            own_q    <= 1'b0;
            rdata0_q <= '0;
            rdata1_q <= '0;
`ifndef DMEM_ARB_FIXED_PRIO_EN
            last_q   <= 1'b1;
`endif
        end else begin
            state_q  <= state_d;
            we_q     <= we_d;
            add_q    <= add_d;
            wdata_q  <= wdata_d;
            own_q    <= own_d;
            rdata0_q <= rdata0_d;
            rdata1_q <= rdata1_d;
`ifndef DMEM_ARB_FIXED_PRIO_EN
            last_q   <= last_d;
`endif
        end
    end

    assign mem_data = bus_drv ? wdata_q : {DATA_W{1'bz}};
    assign rdata0   = rdata0_q;
    assign rdata1   = rdata1_q;

endmodule

// File: tb/tb_dmem_arbiter.sv
// Bench for dmem_arbiter: transaction-phase model checked every cycle plus directed literal checks.
// A weak keeper pattern (0x3C) sits on the bus whenever neither DUT write nor memory read drives it.
module tb_dmem_arbiter;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       req0, req1, we0, we1;
    logic [7:0] add0, add1, wdata0, wdata1;
    logic       gnt0, gnt1, rvalid0, rvalid1, busy, mem_en, mem_wr_rd_n;
    logic [7:0] rdata0, rdata1, mem_add;
    wire  [7:0] mem_data;

    always #5 clk = ~clk;

    dmem_arbiter #(.ADDR_W(8), .DATA_W(8)) dut (
        .clk(clk), .rst_n(rst_n),
        .req0(req0), .req1(req1), .we0(we0), .we1(we1),
        .add0(add0), .add1(add1), .wdata0(wdata0), .wdata1(wdata1),
        .gnt0(gnt0), .gnt1(gnt1), .rvalid0(rvalid0), .rvalid1(rvalid1),
        .rdata0(rdata0), .rdata1(rdata1), .busy(busy),
        .mem_add(mem_add), .mem_data(mem_data), .mem_en(mem_en), .mem_wr_rd_n(mem_wr_rd_n)
    );

    // Environment memory: read data is driven during the cycle after the read access.
    logic [7:0] mem [256];
    logic       mem_rd_drv = 1'b0;
    logic [7:0] rd_addr = 8'h00;
    logic       keep_en;

    initial for (int i = 0; i < 256; i++) mem[i] = 8'(i) ^ 8'h5A;

    always @(posedge clk) begin
        if (mem_en && mem_wr_rd_n) mem[mem_add] <= mem_data;
        mem_rd_drv <= mem_en && !mem_wr_rd_n;
        rd_addr    <= mem_add;
    end

    assign keep_en  = !(mem_en && mem_wr_rd_n) && !mem_rd_drv;
    assign mem_data = mem_rd_drv ? mem[rd_addr] : 8'hzz;
    assign mem_data = keep_en ? 8'h3C : 8'hzz;

    int compared = 0;
    int mismatched = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        compared++;
        if (act !== exp) begin
            mismatched++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Transaction model: phase 0 = idle, 1 = memory access, 2 = read sample, 3 = return.
    logic       chk_en = 1'b0;
    int         m_phase = 0;
    logic       m_port = 1'b0, m_we = 1'b0, m_last = 1'b1;
    logic [7:0] m_add = 8'h00, m_wdata = 8'h00, m_rdata0 = 8'h00, m_rdata1 = 8'h00;
    logic [7:0] m_mem [256];
    logic       e_g0, e_g1, e_rv0, e_rv1, e_en, e_wr, win, take;
    logic [7:0] e_add, e_bus;

    initial for (int i = 0; i < 256; i++) m_mem[i] = 8'(i) ^ 8'h5A;

    always @(negedge clk) begin
        if (chk_en) begin
            e_g0 = 0; e_g1 = 0; e_rv0 = 0; e_rv1 = 0; e_en = 0; e_wr = 0;
            e_add = 8'h00; e_bus = 8'h3C; win = 0; take = 0;
            if (m_phase == 0) begin
                if (rst_n && (req0 || req1)) begin
                    take = 1;
`ifdef DMEM_ARB_FIXED_PRIO_EN
                    win = !req0;
`else
                    win = (req0 && req1) ? !m_last : req1;
`endif
                    e_g0 = !win;
                    e_g1 = win;
                end
            end else if (m_phase == 1) begin
                e_en = 1; e_add = m_add; e_wr = m_we;
                if (m_we) e_bus = m_wdata;
            end else if (m_phase == 2) begin
                e_bus = m_mem[m_add];
            end else begin
                e_rv0 = rst_n && !m_port;
                e_rv1 = rst_n && m_port;
            end
            chk("gnt0", 32'(gnt0), 32'(e_g0));
            chk("gnt1", 32'(gnt1), 32'(e_g1));
            chk("rvalid0", 32'(rvalid0), 32'(e_rv0));
            chk("rvalid1", 32'(rvalid1), 32'(e_rv1));
            chk("busy", 32'(busy), 32'(m_phase != 0));
            chk("mem_en", 32'(mem_en), 32'(e_en));
            chk("mem_wr_rd_n", 32'(mem_wr_rd_n), 32'(e_wr));
            chk("mem_add", 32'(mem_add), 32'(e_add));
            chk("mem_data", 32'(mem_data), 32'(e_bus));
            chk("rdata0", 32'(rdata0), 32'(m_rdata0));
            chk("rdata1", 32'(rdata1), 32'(m_rdata1));
            // Advance to the state after the coming rising edge.
            if (m_phase == 1 && m_we) m_mem[m_add] = m_wdata;
            if (!rst_n) begin
                m_phase = 0; m_rdata0 = 8'h00; m_rdata1 = 8'h00; m_last = 1;
            end else begin
                case (m_phase)
                    0: if (take) begin
                        m_phase = 1; m_port = win; m_last = win;
                        m_we    = win ? we1 : we0;
                        m_add   = win ? add1 : add0;
                        m_wdata = win ? wdata1 : wdata0;
                    end
                    1: m_phase = m_we ? 0 : 2;
                    2: begin
                        if (m_port) m_rdata1 = m_mem[m_add];
                        else        m_rdata0 = m_mem[m_add];
                        m_phase = 3;
                    end
                    default: m_phase = 0;
                endcase
            end
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    int   ng;
    logic gport [8];
    int   gcyc [8];
    logic exp_port [5];

    initial begin
        rst_n = 0; req0 = 0; req1 = 0; we0 = 0; we1 = 0;
        add0 = 8'h00; add1 = 8'h00; wdata0 = 8'h00; wdata1 = 8'h00;
        step(); chk_en = 1;
        step(); rst_n = 1;

        // Write 0xA5 to 0x12 on port 0, then read it back.
        req0 = 1; we0 = 1; add0 = 8'h12; wdata0 = 8'hA5;
        @(negedge clk); chk("t1_gnt0_wr", 32'(gnt0), 32'd1);
        step(); req0 = 0; we0 = 0;
        @(negedge clk);
        chk("t1_acc_en", 32'(mem_en), 32'd1);
        chk("t1_acc_wr", 32'(mem_wr_rd_n), 32'd1);
        chk("t1_acc_bus", 32'(mem_data), 32'hA5);
        step();
        req0 = 1; we0 = 0; add0 = 8'h12;
        @(negedge clk); chk("t1_gnt0_rd", 32'(gnt0), 32'd1);
        step(); req0 = 0;
        step(); step();
        @(negedge clk);
        chk("t1_rvalid0", 32'(rvalid0), 32'd1);
        chk("t1_rdata0", 32'(rdata0), 32'hA5);
        step();

        // Both ports reading continuously from a fresh reset.
        rst_n = 0; step(); rst_n = 1;
        req0 = 1; req1 = 1; add0 = 8'h20; add1 = 8'h21;
        ng = 0;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            if (gnt0 || gnt1) begin
                if (ng < 8) begin gport[ng] = gnt1; gcyc[ng] = i; end
                ng++;
            end
            step();
            if (i == 8)  req0 = 0;
            if (i == 16) req1 = 0;
        end
`ifdef DMEM_ARB_FIXED_PRIO_EN
        exp_port = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b1};
`else
        exp_port = '{1'b0, 1'b1, 1'b0, 1'b1, 1'b1};
`endif
        chk("t2_ngrants", 32'(ng), 32'd5);
        for (int k = 0; k < 5 && k < ng; k++) begin
            chk("t2_port", 32'(gport[k]), 32'(exp_port[k]));
            chk("t2_cycle", 32'(gcyc[k]), 32'(4 * k));
        end

        // Reset in the read-sample cycle of a port 1 read.
        req1 = 1; we1 = 0; add1 = 8'h30;
        @(negedge clk); chk("t3_gnt1", 32'(gnt1), 32'd1);
        step(); req1 = 0;
        step(); rst_n = 0;
        step(); req1 = 1;
        @(negedge clk);
        chk("t3_gnt_supp", 32'(gnt1), 32'd0);
        chk("t3_busy", 32'(busy), 32'd0);
        chk("t3_rvalid1", 32'(rvalid1), 32'd0);
        chk("t3_mem_en", 32'(mem_en), 32'd0);
        chk("t3_rdata0", 32'(rdata0), 32'd0);
        chk("t3_rdata1", 32'(rdata1), 32'd0);
        chk("t3_bus", 32'(mem_data), 32'h3C);
        step(); rst_n = 1;
        @(negedge clk); chk("t3_gnt1_after", 32'(gnt1), 32'd1);
        step(); req1 = 0;
        step(); step(); step();

        // Address change right after grant must not reach the memory.
        req1 = 1; we1 = 0; add1 = 8'h05;
        @(negedge clk); chk("t4_gnt1", 32'(gnt1), 32'd1);
        step(); add1 = 8'h06; req1 = 0;
        @(negedge clk); chk("t4_mem_add", 32'(mem_add), 32'h05);
        step(); step();
        @(negedge clk); chk("t4_rdata1", 32'(rdata1), 32'h5F);
        step();

        // Back-to-back writes on port 0, then read the second one on port 1.
        req0 = 1; we0 = 1; add0 = 8'h40; wdata0 = 8'h11;
        @(negedge clk); chk("t5_gnt0", 32'(gnt0), 32'd1);
        step(); add0 = 8'h41; wdata0 = 8'h22;
        @(negedge clk); chk("t5_no_gnt_acc", 32'(gnt0), 32'd0);
        step();
        @(negedge clk); chk("t5_gnt0_b2b", 32'(gnt0), 32'd1);
        step(); req0 = 0; we0 = 0;
        step();
        req1 = 1; we1 = 0; add1 = 8'h41;
        @(negedge clk); chk("t5_gnt1", 32'(gnt1), 32'd1);
        step(); req1 = 0;
        step(); step();
        @(negedge clk); chk("t5_rdata1", 32'(rdata1), 32'h22);
        step();

        // Simultaneous port 0 read and port 1 write to the same address.
        req0 = 1; we0 = 0; add0 = 8'h50;
        req1 = 1; we1 = 1; add1 = 8'h50; wdata1 = 8'h77;
        @(negedge clk); chk("t6_gnt0", 32'(gnt0), 32'd1);
        step(); req0 = 0;
        step(); step();
        @(negedge clk); chk("t6_rdata0", 32'(rdata0), 32'h0A);
        step();
        @(negedge clk); chk("t6_gnt1", 32'(gnt1), 32'd1);
        step(); req1 = 0; we1 = 0;
        step(); step(); step();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
